// File: rtl/sram_b_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sram_b_pkg
// Purpose  : Shared geometry helpers for the parametrised banked SRAM.
//            clog2 / ceil_div size the bank grid; num_rows and sel_width
//            give the vertical bank count and the row-select register width.
// Revision : 1.0 - initial release
// ============================================================================
package sram_b_pkg;

  function automatic int clog2(input int value);
    int w;
    w = 0;
    while ((1 << w) < value) w++;
    return w;
  endfunction

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Vertical bank count: one row per combination of address MSBs.
  function automatic int num_rows(input int addr_w, input int bank_addr_w);
    return 1 << (addr_w - bank_addr_w);
  endfunction

  // A single-row memory still carries a 1-bit (always zero) select.
  function automatic int sel_width(input int addr_w, input int bank_addr_w);
    int w;
    w = clog2(num_rows(addr_w, bank_addr_w));
    return (w > 0) ? w : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/unisim_sram_b_bank_row.sv
`default_nettype none
// ============================================================================
// Module   : unisim_sram_b_bank_row
// Purpose  : One vertical row of the banked SRAM: NH primitives side by side,
//            each BANK_DATA_W wide and 2^BANK_ADDR_W deep. Port 0 writes,
//            port 1 reads (registered output, read-first).
//            The last slice is zero-padded; its padded Q bits are dropped.
// Ports    : clk                     clock
//            i_wr_ce / i_wr_addr     row write enable / bank address
//            i_wr_data / i_wr_mask   write data / per-bit mask (1 = write)
//            i_rd_ce / i_rd_addr     row read enable / bank address
//            o_q                     registered read data
// Revision : 1.0 - initial release
// ============================================================================
module unisim_sram_b_bank_row
  import sram_b_pkg::*;
#(
  parameter int BANK_ADDR_W = 14,
  parameter int DATA_W      = 8,
  parameter int BANK_DATA_W = 1
) (
  input  logic                   clk,
  input  logic                   i_wr_ce,
  input  logic [BANK_ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]      i_wr_data,
  input  logic [DATA_W-1:0]      i_wr_mask,
  input  logic                   i_rd_ce,
  input  logic [BANK_ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0]      o_q
);

  localparam int NH    = ceil_div(DATA_W, BANK_DATA_W);
  localparam int PAD_W = NH * BANK_DATA_W;
  localparam int DEPTH = 1 << BANK_ADDR_W;

  logic [PAD_W-1:0] w_d_pad;
  logic [PAD_W-1:0] w_m_pad;
  logic [PAD_W-1:0] w_q_pad;

  // Zero mask on padding bits keeps them permanently unwritten.
  assign w_d_pad = PAD_W'(i_wr_data);
  assign w_m_pad = PAD_W'(i_wr_mask);

  generate
    for (genvar s = 0; s < NH; s++) begin : g_slice
      logic [BANK_DATA_W-1:0] r_mem [0:DEPTH-1];
      logic [BANK_DATA_W-1:0] r_q;
      logic [BANK_DATA_W-1:0] w_wd;
      logic [BANK_DATA_W-1:0] w_wm;

      assign w_wd = w_d_pad[s*BANK_DATA_W +: BANK_DATA_W];
      assign w_wm = w_m_pad[s*BANK_DATA_W +: BANK_DATA_W];

      always_ff @(posedge clk) begin
        if (i_wr_ce) begin
          r_mem[i_wr_addr] <= (r_mem[i_wr_addr] & ~w_wm) | (w_wd & w_wm);
        end
        if (i_rd_ce) begin
          r_q <= r_mem[i_rd_addr];
        end
      end

      assign w_q_pad[s*BANK_DATA_W +: BANK_DATA_W] = r_q;
    end

    if (PAD_W > DATA_W) begin : g_pad
      logic w_unused_pad;
      assign w_unused_pad = ^w_q_pad[PAD_W-1:DATA_W];
    end
  endgenerate

  assign o_q = w_q_pad[DATA_W-1:0];

endmodule
`default_nettype wire

// File: rtl/unisim_sram_b_param.sv
`default_nettype none
// ============================================================================
// Module   : unisim_sram_b_param
// Purpose  : Parametrised 1W/1R banked SRAM. Tiles bank rows vertically on
//            the address MSBs, forwards same-cycle write data to a colliding
//            read, optionally registers the output, strobes read-valid and
//            counts collisions with a saturating counter.
// Ports    : CLK, RSTN (async, active-low)
//            CE0, A0, D0, WE0, WEM0   write port (WEM0 bit 1 = write bit)
//            CE1, A1                  read port request
//            Q1, Q1_VALID             read data / one-cycle valid per read
//            CLR_CNT, COLL_CNT        counter clear / saturating count
// Revision : 1.0 - initial release
// ============================================================================
module unisim_sram_b_param
  import sram_b_pkg::*;
#(
  parameter int ADDR_W      = 15,
  parameter int DATA_W      = 8,
  parameter int BANK_ADDR_W = 14,
  parameter int BANK_DATA_W = 1,
  parameter int OUT_REG     = 0,
  parameter int CNT_W       = 16
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              CE0,
  input  logic [ADDR_W-1:0] A0,
  input  logic [DATA_W-1:0] D0,
  input  logic              WE0,
  input  logic [DATA_W-1:0] WEM0,
  input  logic              CE1,
  input  logic [ADDR_W-1:0] A1,
  output logic [DATA_W-1:0] Q1,
  output logic              Q1_VALID,
  input  logic              CLR_CNT,
  output logic [CNT_W-1:0]  COLL_CNT
);

  localparam int NV    = num_rows(ADDR_W, BANK_ADDR_W);
  localparam int SEL_W = sel_width(ADDR_W, BANK_ADDR_W);
  localparam int NQ    = 1 << SEL_W;
  localparam logic [CNT_W-1:0] C_CNT_MAX = '1;

  typedef struct packed {
    logic              en;
    logic [DATA_W-1:0] mask;
    logic [DATA_W-1:0] data;
  } fwd_rec_t;

  logic              w_wr_en;
  logic              w_rd_en;
  logic              w_coll;
  logic [SEL_W-1:0]  w_wr_row;
  logic [SEL_W-1:0]  w_rd_row;
  logic [DATA_W-1:0] w_bank_q [NQ];
  logic [DATA_W-1:0] w_fwd_mask;
  logic [DATA_W-1:0] w_word;

  logic              r_rd_valid;
  logic [SEL_W-1:0]  r_rd_row;
  fwd_rec_t          r_fwd;
  logic [CNT_W-1:0]  r_coll_cnt;

  // Reset gates every bank enable so inputs are ignored while RSTN is low.
  assign w_wr_en  = RSTN & CE0 & WE0;
  assign w_rd_en  = RSTN & CE1;
  assign w_coll   = w_wr_en & w_rd_en & (A0 == A1);
  // Shift rather than slice so a single-row memory (ADDR_W == BANK_ADDR_W)
  // elaborates with a zero select.
  assign w_wr_row = SEL_W'(A0 >> BANK_ADDR_W);
  assign w_rd_row = SEL_W'(A1 >> BANK_ADDR_W);

  generate
    for (genvar r = 0; r < NQ; r++) begin : g_row
      if (r < NV) begin : g_bank
        unisim_sram_b_bank_row #(
          .BANK_ADDR_W (BANK_ADDR_W),
          .DATA_W      (DATA_W),
          .BANK_DATA_W (BANK_DATA_W)
        ) u_row (
          .clk       (CLK),
          .i_wr_ce   (w_wr_en && (w_wr_row == SEL_W'(r))),
          .i_wr_addr (A0[BANK_ADDR_W-1:0]),
          .i_wr_data (D0),
          .i_wr_mask (WEM0),
          .i_rd_ce   (w_rd_en && (w_rd_row == SEL_W'(r))),
          .i_rd_addr (A1[BANK_ADDR_W-1:0]),
          .o_q       (w_bank_q[r])
        );
      end else begin : g_empty
        assign w_bank_q[r] = '0;
      end
    end
  endgenerate

  // Select and forward state are captured with the read so the returned
  // word is assembled one cycle later, alongside the bank output register.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_rd_valid <= 1'b0;
      r_rd_row   <= '0;
      r_fwd      <= '0;
    end else begin
      r_rd_valid <= w_rd_en;
      if (w_rd_en) begin
        r_rd_row <= w_rd_row;
        r_fwd.en <= w_coll;
        if (w_coll) begin
          r_fwd.mask <= WEM0;
          r_fwd.data <= D0;
        end
      end
    end
  end

  assign w_fwd_mask = r_fwd.en ? r_fwd.mask : '0;
  assign w_word     = (r_fwd.data & w_fwd_mask) | (w_bank_q[r_rd_row] & ~w_fwd_mask);

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [DATA_W-1:0] r_q_pipe;
      logic              r_v_pipe;

      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          r_q_pipe <= '0;
          r_v_pipe <= 1'b0;
        end else begin
          r_v_pipe <= r_rd_valid;
          if (r_rd_valid) r_q_pipe <= w_word;
        end
      end

      assign Q1       = r_q_pipe;
      assign Q1_VALID = r_v_pipe;
    end else begin : g_out_comb
      logic [DATA_W-1:0] r_hold;

      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          r_hold <= '0;
        end else if (r_rd_valid) begin
          r_hold <= w_word;
        end
      end

      assign Q1       = r_rd_valid ? w_word : r_hold;
      assign Q1_VALID = r_rd_valid;
    end
  endgenerate

  // Clear wins over a coincident collision.
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_coll_cnt <= '0;
    end else if (CLR_CNT) begin
      r_coll_cnt <= '0;
    end else if (w_coll && (r_coll_cnt != C_CNT_MAX)) begin
      r_coll_cnt <= r_coll_cnt + 1'b1;
    end
  end

  assign COLL_CNT = r_coll_cnt;

`ifndef SYNTHESIS
  generate
    if (BANK_ADDR_W > ADDR_W) begin : g_geom_check
      always_ff @(posedge CLK) $finish;
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RSTN && ($isunknown(CE0) || $isunknown(CE1))) $finish;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_unisim_sram_b_param.sv
`default_nettype none
// ============================================================================
// Module   : tb_unisim_sram_b_param
// Purpose  : Directed bench for unisim_sram_b_param. Three 8-bit instances
//            share one stimulus bundle (OUT_REG=0, OUT_REG=1, CNT_W=2); a
//            fourth 10-bit instance (BANK_DATA_W=4) has its own bundle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unisim_sram_b_param;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        ce0 = 1'b0, we0 = 1'b0, ce1 = 1'b0, clr = 1'b0;
  logic [14:0] a0 = '0, a1 = '0;
  logic [7:0]  d0 = '0, wem0 = '0;

  logic [7:0]  q_0, q_1, q_2;
  logic        v_0, v_1, v_2;
  logic [15:0] cnt_0, cnt_1;
  logic [1:0]  cnt_2;

  logic        b_ce0 = 1'b0, b_we0 = 1'b0, b_ce1 = 1'b0, b_clr = 1'b0;
  logic [14:0] b_a0 = '0, b_a1 = '0;
  logic [9:0]  b_d0 = '0, b_wem0 = '0;
  logic [9:0]  q_3;
  logic        v_3;
  logic [15:0] cnt_3;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  unisim_sram_b_param #(.OUT_REG(0)) dut0 (
    .CLK(clk), .RSTN(rstn), .CE0(ce0), .A0(a0), .D0(d0), .WE0(we0), .WEM0(wem0),
    .CE1(ce1), .A1(a1), .Q1(q_0), .Q1_VALID(v_0), .CLR_CNT(clr), .COLL_CNT(cnt_0));

  unisim_sram_b_param #(.OUT_REG(1)) dut1 (
    .CLK(clk), .RSTN(rstn), .CE0(ce0), .A0(a0), .D0(d0), .WE0(we0), .WEM0(wem0),
    .CE1(ce1), .A1(a1), .Q1(q_1), .Q1_VALID(v_1), .CLR_CNT(clr), .COLL_CNT(cnt_1));

  unisim_sram_b_param #(.CNT_W(2)) dut2 (
    .CLK(clk), .RSTN(rstn), .CE0(ce0), .A0(a0), .D0(d0), .WE0(we0), .WEM0(wem0),
    .CE1(ce1), .A1(a1), .Q1(q_2), .Q1_VALID(v_2), .CLR_CNT(clr), .COLL_CNT(cnt_2));

  unisim_sram_b_param #(.DATA_W(10), .BANK_DATA_W(4)) dut3 (
    .CLK(clk), .RSTN(rstn), .CE0(b_ce0), .A0(b_a0), .D0(b_d0), .WE0(b_we0), .WEM0(b_wem0),
    .CE1(b_ce1), .A1(b_a1), .Q1(q_3), .Q1_VALID(v_3), .CLR_CNT(b_clr), .COLL_CNT(cnt_3));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ce0 = 1'b0; we0 = 1'b0; ce1 = 1'b0; clr = 1'b0;
  endtask

  task automatic wr(input logic [14:0] a, input logic [7:0] d, input logic [7:0] m);
    ce0 = 1'b1; we0 = 1'b1; a0 = a; d0 = d; wem0 = m; ce1 = 1'b0;
  endtask

  task automatic rd(input logic [14:0] a);
    ce0 = 1'b0; we0 = 1'b0; ce1 = 1'b1; a1 = a;
  endtask

  task automatic coll(input logic [14:0] a, input logic [7:0] d, input logic [7:0] m);
    ce0 = 1'b1; we0 = 1'b1; a0 = a; d0 = d; wem0 = m; ce1 = 1'b1; a1 = a;
  endtask

  initial begin
    // ---------------- reset state ----------------
    idle();
    step(); step();
    check("rst_q0", q_0, 8'h00);     check("rst_v0", v_0, 1'b0);
    check("rst_q1", q_1, 8'h00);     check("rst_v1", v_1, 1'b0);
    check("rst_cnt0", cnt_0, 0);     check("rst_cnt2", cnt_2, 0);
    check("rst_q3", q_3, 10'h000);   check("rst_v3", v_3, 1'b0);
    rstn = 1'b1;
    step();
    check("idle_v0", v_0, 1'b0);

    // ---------------- basic write/read, two vertical banks ----------------
    wr(15'h4123, 8'hA5, 8'hFF); step();
    wr(15'h0123, 8'h00, 8'hFF); step();
    rd(15'h4123); step();
    check("rd_hi_q0", q_0, 8'hA5);   check("rd_hi_v0", v_0, 1'b1);
    check("rd_hi_v1_early", v_1, 1'b0);
    rd(15'h0123); step();
    check("rd_lo_q0", q_0, 8'h00);   check("rd_lo_v0", v_0, 1'b1);
    check("rd_hi_q1", q_1, 8'hA5);   check("rd_hi_v1", v_1, 1'b1);
    wr(15'h0010, 8'h3C, 8'hFF); step();
    check("hold_q0", q_0, 8'h00);    check("hold_v0", v_0, 1'b0);
    check("rd_lo_q1", q_1, 8'h00);

    // ---------------- masked collision ----------------
    coll(15'h0010, 8'hF0, 8'h0F); step();
    check("coll_q0", q_0, 8'h30);    check("coll_v0", v_0, 1'b1);
    check("coll_cnt0", cnt_0, 1);    check("coll_cnt2", cnt_2, 1);
    check("coll_v1_early", v_1, 1'b0);
    rd(15'h0010); step();
    check("after_coll_q0", q_0, 8'h30);
    check("coll_q1", q_1, 8'h30);    check("coll_v1", v_1, 1'b1);
    // equal addresses but WE0=0: not a write, not a collision
    ce0 = 1'b1; we0 = 1'b0; a0 = 15'h0010; d0 = 8'hFF; wem0 = 8'hFF;
    ce1 = 1'b1; a1 = 15'h0010; step();
    check("nowe_q0", q_0, 8'h30);    check("nowe_cnt0", cnt_0, 1);
    idle(); step();
    check("nowe_hold_q0", q_0, 8'h30); check("nowe_hold_v0", v_0, 1'b0);
    check("nowe_q1", q_1, 8'h30);
    step();
    check("drain_v1", v_1, 1'b0);

    // ---------------- OUT_REG=1 back-to-back reads ----------------
    wr(15'h0000, 8'h11, 8'hFF); step();
    wr(15'h0001, 8'h22, 8'hFF); step();
    wr(15'h0002, 8'h33, 8'hFF); step();
    rd(15'h0000); step();
    check("pipe0_v1", v_1, 1'b0);    check("pipe0_q0", q_0, 8'h11);
    rd(15'h0001); step();
    check("pipe1_q1", q_1, 8'h11);   check("pipe1_v1", v_1, 1'b1);
    rd(15'h0002); step();
    check("pipe2_q1", q_1, 8'h22);   check("pipe2_v1", v_1, 1'b1);
    check("pipe2_q0", q_0, 8'h33);
    idle(); step();
    check("pipe3_q1", q_1, 8'h33);   check("pipe3_v1", v_1, 1'b1);
    step();
    check("pipe_end_v1", v_1, 1'b0); check("pipe_hold_q1", q_1, 8'h33);
    step();
    check("pipe_hold2_q1", q_1, 8'h33);

    // ---------------- saturating counter ----------------
    clr = 1'b1; step();
    check("clr_cnt0", cnt_0, 0);     check("clr_cnt2", cnt_2, 0);
    clr = 1'b0;
    for (int i = 0; i < 5; i++) begin
      coll(15'h0020, 8'(8'h70 + i), 8'hFF); step();
      check("sat_cnt2", cnt_2, (i < 3) ? (i + 1) : 3);
      check("sat_cnt0", cnt_0, i + 1);
      check("sat_q0", q_0, 8'h70 + i);
    end
    clr = 1'b1; coll(15'h0020, 8'h77, 8'hFF); step();
    check("clrcoll_cnt2", cnt_2, 0); check("clrcoll_cnt0", cnt_0, 0);
    check("clrcoll_q0", q_0, 8'h77);
    clr = 1'b0; coll(15'h0020, 8'h78, 8'hFF); step();
    check("recount_cnt2", cnt_2, 1); check("recount_cnt0", cnt_0, 1);
    idle(); step(); step();

    // ---------------- reset while a read is in flight ----------------
    rd(15'h4123); step();
    rstn = 1'b0; idle();
    #1;
    check("rstfl_q0", q_0, 8'h00);   check("rstfl_v0", v_0, 1'b0);
    check("rstfl_q1", q_1, 8'h00);   check("rstfl_v1", v_1, 1'b0);
    check("rstfl_cnt0", cnt_0, 0);
    step();
    check("rstfl2_v1", v_1, 1'b0);
    step();
    rstn = 1'b1;
    step();
    check("post_rst_v0", v_0, 1'b0); check("post_rst_v1", v_1, 1'b0);
    step();
    check("post_rst2_v1", v_1, 1'b0); check("post_rst2_q1", q_1, 8'h00);
    rd(15'h4123); step();
    check("retain_q0", q_0, 8'hA5);
    rd(15'h0020); step();
    check("retain_q1", q_1, 8'hA5);  check("retain2_q0", q_0, 8'h78);
    idle(); step();

    // ---------------- 10-bit word over 4-bit slices ----------------
    b_ce0 = 1'b1; b_we0 = 1'b1; b_a0 = 15'h0005; b_d0 = 10'h000; b_wem0 = 10'h3FF; step();
    b_d0 = 10'h3FF; b_wem0 = 10'h201; step();
    b_a0 = 15'h4006; b_d0 = 10'h2AA; b_wem0 = 10'h3FF; step();
    b_ce0 = 1'b0; b_we0 = 1'b0; b_ce1 = 1'b1; b_a1 = 15'h0005; step();
    check("pad_q3", q_3, 10'h201);   check("pad_v3", v_3, 1'b1);
    b_a1 = 15'h4006; step();
    check("pad2_q3", q_3, 10'h2AA);
    b_ce1 = 1'b0; step();
    check("pad_hold_q3", q_3, 10'h2AA); check("pad_hold_v3", v_3, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
